// File: rtl/serial_paralelo_phy_rx.sv
// serial_paralelo_phy_rx: serial-to-parallel receive PHY.
// Shifts in one bit per clk_32f edge (MSB of each byte first), finds byte
// alignment on the COM character, requires COM_NEEDED consecutive aligned
// COMs before declaring the link active, then emits payload bytes (anything
// other than COM/IDL) with a one-cycle valid_out strobe.
//
// Handshake: valid_out is a pure one-cycle strobe with no back-pressure.
// When valid_out is high, data_out holds a payload byte for that cycle only.
// data_out itself keeps the last aligned byte (including COM/IDL) until the
// next byte boundary.
//
// Optional feature: define SYNC_LOSS_EN to drop back to HUNT after LOSS_BYTES
// consecutive aligned bytes in ACTIVE without a COM. Without the macro, ACTIVE
// persists until reset and no loss counter exists.
module serial_paralelo_phy_rx #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [7:0] IDL        = 8'h7C,
    parameter int         COM_NEEDED = 4,
    parameter int         LOSS_BYTES = 32
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int CW = (COM_NEEDED < 2) ? 1 : $clog2(COM_NEEDED + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      sr;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_cnt_nx;
    logic [CW-1:0]   com_cnt;
    logic [CW-1:0]   com_cnt_nx;
    logic [7:0]      data_nx;
    logic            valid_nx;

    // The byte that completes on this edge: seven stored bits plus the live bit.
    logic [7:0]      window;
    logic            is_com;
    logic            is_idl;
    logic            boundary;

    assign window   = {sr[6:0], data_in};
    assign is_com   = (window == COM);
    assign is_idl   = (window == IDL);
    assign boundary = (state != HUNT) && (bit_cnt == 3'd7);

`ifdef SYNC_LOSS_EN
    localparam int LW = (LOSS_BYTES < 2) ? 1 : $clog2(LOSS_BYTES + 1);
    logic [LW-1:0]   loss_cnt;
    logic [LW-1:0]   loss_cnt_nx;
`endif

    // Next-state and next-output decode; defaults hold state and drop the strobe.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        com_cnt_nx = com_cnt;
        data_nx    = data_out;
        valid_nx   = 1'b0;
`ifdef SYNC_LOSS_EN
        loss_cnt_nx = loss_cnt;
`endif
        case (state)
            HUNT: begin
                // Bit-level search: any edge whose window equals COM sets alignment.
                if (is_com) begin
                    state_nx   = SYNC;
                    bit_cnt_nx = 3'd0;
                    com_cnt_nx = CW'(1);
                end
            end
            SYNC: begin
                bit_cnt_nx = bit_cnt + 3'd1;
                if (boundary) begin
                    data_nx = window;
                    if (is_com) begin
                        if (com_cnt == CW'(COM_NEEDED - 1)) begin
                            state_nx = ACTIVE;
                        end else begin
                            com_cnt_nx = com_cnt + CW'(1);
                        end
                    end else begin
                        state_nx   = HUNT;
                        com_cnt_nx = '0;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_nx = bit_cnt + 3'd1;
                if (boundary) begin
                    data_nx  = window;
                    valid_nx = !is_com && !is_idl;
`ifdef SYNC_LOSS_EN
                    if (is_com) begin
                        loss_cnt_nx = '0;
                    end else if (loss_cnt == LW'(LOSS_BYTES - 1)) begin
                        state_nx    = HUNT;
                        com_cnt_nx  = '0;
                        bit_cnt_nx  = 3'd0;
                        loss_cnt_nx = '0;
                    end else begin
                        loss_cnt_nx = loss_cnt + LW'(1);
                    end
`endif
                end
            end
            default: begin
                state_nx   = HUNT;
                com_cnt_nx = '0;
                bit_cnt_nx = 3'd0;
            end
        endcase
    end

    // State, shift register and output registers; reset overrides every event.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            com_cnt   <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nx;
            sr        <= window;
            bit_cnt   <= bit_cnt_nx;
            com_cnt   <= com_cnt_nx;
            data_out  <= data_nx;
            valid_out <= valid_nx;
        end
    end

`ifdef SYNC_LOSS_EN
    // Aligned bytes seen in ACTIVE since the last COM.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            loss_cnt <= '0;
        end else begin
            loss_cnt <= loss_cnt_nx;
        end
    end
`endif

    assign active = (state == ACTIVE);

endmodule

// File: doc/serial_paralelo_phy_rx.md
SERIAL_PARALELO_PHY_RX -- requirements
Module: serial_paralelo_phy_rx

Interface
REQ-001 SHALL provide parameter COM, default 8'hBC: comma/alignment character.
REQ-002 SHALL provide parameter IDL, default 8'h7C: idle character.
REQ-003 SHALL provide parameter COM_NEEDED, default 4: consecutive aligned COM bytes required to go active.
REQ-004 SHALL provide parameter LOSS_BYTES, default 32: bytes without COM that trigger sync loss (used only with SYNC_LOSS_EN).
REQ-005 clk_32f  input  1  bit clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  1  serial bit stream, MSB of each byte first.
REQ-008 data_out  output  8  last aligned byte received, registered.
REQ-009 valid_out  output  1  one-cycle strobe: data_out holds a payload byte (not COM/IDL).
REQ-010 active  output  1  high while the link is in ACTIVE state.

Function
REQ-011 SHALL shift data_in into an 8-bit register each edge; window W = {sr[6:0], data_in} at that edge.
REQ-012 SHALL implement states HUNT, SYNC, ACTIVE with a 3-bit bit counter and a COM counter.
REQ-013 HUNT: bit-level search; on W==COM SHALL set bit_cnt=0, com_cnt=1, go SYNC; else stay.
REQ-014 Byte boundary SHALL be an edge with bit_cnt==7 in SYNC/ACTIVE; bit_cnt wraps 7->0, increments otherwise.
REQ-015 SYNC at boundary: W==COM and com_cnt==COM_NEEDED-1 -> ACTIVE, active=1 on that edge; W==COM otherwise -> com_cnt+1; W!=COM -> HUNT, com_cnt=0.
REQ-016 SHALL load data_out<=W at every byte boundary in SYNC and ACTIVE; data_out holds between boundaries and in HUNT.
REQ-017 ACTIVE at boundary: valid_out=1 for one cycle iff W!=COM and W!=IDL; valid_out=0 at all other edges.
REQ-018 Latency: byte whose last bit is sampled at edge N SHALL appear on data_out/valid_out after edge N (1 cycle).
REQ-019 COM/IDL inside ACTIVE SHALL be consumed silently; alignment SHALL NOT re-hunt while ACTIVE.
REQ-020 First boundary in ACTIVE SHALL occur 8 edges after the transition edge.

Reset
REQ-021 reset high at an edge SHALL force state=HUNT, sr=0, bit_cnt=0, com_cnt=0, data_out=8'h00, valid_out=0, active=0, loss counter=0.
REQ-022 Reset asserted mid-byte or in ACTIVE SHALL take precedence over all other events at that edge.
REQ-023 After reset release, a COM SHALL need 8 fresh bits to be detected (cleared sr cannot match).

Configuration
REQ-024 Macro SYNC_LOSS_EN: when defined, SHALL count byte boundaries in ACTIVE since last COM; COM clears it; reaching LOSS_BYTES SHALL go HUNT, active=0, com_cnt=0 on that edge.
REQ-025 Without SYNC_LOSS_EN, ACTIVE SHALL persist until reset; no loss counter logic present.

Verification
REQ-026 After reset, send BC x4 MSB-first -> active rises on the edge sampling last bit of 4th BC; valid_out stays 0.
REQ-027 3 random bits, then BC x4, then 7C x2, then 8'h5A -> active=1, no strobes for 7C, one valid_out pulse with data_out=8'h5A.
REQ-028 BC, BC, 8'h3C, BC x4 -> returns to HUNT on 8'h3C, active only after the last 4 BC.
REQ-029 Active link, then reset for 1 cycle during a payload byte -> all outputs 0 next cycle; relock requires 4 fresh BC.
REQ-030 SYNC_LOSS_EN defined, active link, 32 payload bytes 8'h11 without COM -> active falls at 32nd boundary; without macro, active stays 1.
REQ-031 Back-to-back payload 8'h01..8'h08 -> eight valid_out pulses exactly 8 cycles apart, data_out in order.
